byte_sample_assembler: RTL
==========================

# byte_sample_assembler

Parametrised front-end that turns the byte-wide, MSB-first input stream into DATA_WIDTH-bit samples and delivers each one to one of NUM_UNITS detector channels.

- Generalises the fixed two-unit, 16-bit feed in sample width and channel count.
- Adds a round-robin distribution mode, partial-sample timeout and flush recovery, and drop accounting.
- Sits between the top-level pin mapping (ui_in/uio_in) and the per-unit detector array.

## Interface
Parameters:
- NUM_UNITS, 4, number of destination channels (1..16); SEL_W = max(1, clog2(NUM_UNITS)) is derived, not settable.
- DATA_WIDTH, 16, sample width; multiple of 8, range 8..32; BYTES = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, idle cycles tolerated inside a partial sample (1..1023).

Ports:
- clk  in  1  clock; one clock domain; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- byte_in  in  8  stream byte, MSB-first within a sample.
- byte_valid  in  1  byte_in is accepted on this edge.
- mode  in  1  0 = explicit select via chan_sel, 1 = round-robin.
- chan_sel  in  SEL_W  destination channel in mode 0.
- flush  in  1  discards any partial sample.
- sample_out  out  DATA_WIDTH  last completed sample; held until the next completion.
- sample_valid  out  NUM_UNITS  one-hot, single-cycle strobe to the destination channel.
- sample_chan  out  SEL_W  index of the channel of the last completed sample.
- busy  out  1  partial sample in progress: at least 1 byte held and fewer than BYTES.
- err_timeout  out  1  single-cycle pulse on a timeout abort.
- drop_count  out  8  saturating count of discarded samples.

## Operation
State machine has two states, IDLE and ASSEMBLE. It keeps a byte counter (0..BYTES-1), a shift register, the latched channel `cur_chan`, a round-robin pointer `rr_ptr` and an idle counter.

- **IDLE, byte_valid=1, flush=0:**
  - Latch cur_chan: chan_sel in mode 0, rr_ptr in mode 1.
  - Shift in the byte and set the counter to 1.
  - Go to ASSEMBLE. If BYTES==1, complete immediately instead.
- **ASSEMBLE, byte_valid=1:** shift left by 8, insert byte_in at the LSB, increment the counter, clear the idle counter.
- **Completion** (the byte that makes the counter equal BYTES):
  - Register sample_out = {held bytes, byte_in} and sample_chan = cur_chan.
  - Pulse sample_valid[cur_chan].
  - In mode 1, advance rr_ptr = (rr_ptr+1) mod NUM_UNITS.
  - Return to IDLE.
- **ASSEMBLE, byte_valid=0:** increment the idle counter. When it reaches TIMEOUT_CYCLES:
  - Abort: discard the partial sample and pulse err_timeout.
  - Increment drop_count and go to IDLE.
  - A byte arriving on that same edge wins; there is no abort.
- **flush=1:** has priority over byte_valid; any byte presented on that edge is ignored.
  - If busy, discard the partial sample and increment drop_count.
  - Go to IDLE. rr_ptr is unchanged.
- **Invalid channel:** if cur_chan >= NUM_UNITS in mode 0, completion produces no strobe and leaves sample_out/sample_chan unchanged. drop_count increments.
- **Mode or chan_sel change mid-sample:** no effect; the channel is latched on the first byte. A mode change takes effect from the next sample's first byte.
- **drop_count:** saturates at 255; never wraps.
- **Width rules:** shift register is DATA_WIDTH-8 bits (empty when BYTES==1). The idle counter is clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- **Reset values:** sample_out=0, sample_valid=0, sample_chan=0, busy=0, err_timeout=0, drop_count=0. Internally rr_ptr=0 and the state is IDLE.
- **Reset mid-sample:** the partial sample is lost silently; drop_count is cleared, not incremented.
- **Latency:** all outputs are registered. sample_valid is high in the cycle after the edge that accepts the last byte, for exactly 1 cycle.
- **Throughput:** 1 byte/cycle sustained. A byte accepted while sample_valid is high starts the next sample; there are no bubbles. Back-to-back samples strobe every BYTES cycles.
- **busy:** rises the cycle after the first accepted byte; falls the cycle after completion, abort or flush.
- **err_timeout:** high for 1 cycle, in the cycle after the TIMEOUT_CYCLES-th consecutive idle cycle.
- **No back-pressure:** downstream units must accept every strobe.

## Test plan
- **Explicit select:** mode 0, chan_sel=1, bytes 0xAB then 0xCD on consecutive cycles → next cycle sample_valid=4'b0010 for 1 cycle, sample_out=0xABCD, sample_chan=1, busy 1→0.
- **Round-robin:** mode 1, 8 back-to-back bytes 0x01..0x08 → strobes on ch0..ch3 every 2 cycles with 0x0102, 0x0304, 0x0506, 0x0708. The 9th+10th bytes land on ch0.
- **Timeout:** TIMEOUT_CYCLES=4, one byte 0x11, then 4 idle cycles → err_timeout pulse, drop_count=1, busy=0. A following 0x22, 0x33 yields 0x2233, not 0x1122.
- **Flush vs byte:** flush=1 and byte_valid=1 on the 2nd byte of a sample → no strobe, drop_count+1. The next two bytes form a clean sample.
- **Invalid channel:** NUM_UNITS=3, mode 0, chan_sel=3 → no sample_valid bit set, drop_count+1, sample_out unchanged.
- **Reset and saturation:** assert rst mid-sample → all outputs 0 next cycle. Then 300 flush-aborted partial samples → drop_count stays at 255.

Source files
------------

// File: rtl/byte_sample_assembler.sv
// Assembles an MSB-first byte stream into DATA_WIDTH-bit samples and strobes
// each completed sample to one of NUM_UNITS channels (explicit or round-robin).
module byte_sample_assembler #(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned SEL_W         = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      chan_sel,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic [NUM_UNITS-1:0]  sample_valid,
  output logic [SEL_W-1:0]      sample_chan,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [7:0]            drop_count
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned SR_W   = (BYTES > 1) ? DATA_WIDTH - 8 : 8;
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, ASSEMBLE} state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [SR_W-1:0]       shreg, shreg_d;
  logic [SEL_W-1:0]      cur_chan, cur_chan_d;
  logic                  cur_mode, cur_mode_d;
  logic [SEL_W-1:0]      rr_ptr, rr_ptr_d;
  logic [IDLE_W-1:0]     idle_cnt, idle_cnt_d;
  logic [DATA_WIDTH-1:0] sample_out_d;
  logic [NUM_UNITS-1:0]  sample_valid_d;
  logic [SEL_W-1:0]      sample_chan_d;
  logic                  busy_d;
  logic                  err_timeout_d;
  logic [7:0]            drop_count_d;

  logic                  done;
  logic                  drop_inc;
  logic [SEL_W-1:0]      done_chan;
  logic                  done_mode;

  // Next-state, datapath and output computation
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    shreg_d        = shreg;
    cur_chan_d     = cur_chan;
    cur_mode_d     = cur_mode;
    rr_ptr_d       = rr_ptr;
    idle_cnt_d     = idle_cnt;
    sample_out_d   = sample_out;
    sample_valid_d = '0;
    sample_chan_d  = sample_chan;
    err_timeout_d  = 1'b0;
    drop_count_d   = drop_count;
    done           = 1'b0;
    drop_inc       = 1'b0;
    done_chan      = cur_chan;
    done_mode      = cur_mode;

    if (flush) begin
      // flush wins over any byte presented on the same edge
      if (state == ASSEMBLE) drop_inc = 1'b1;
      state_d    = IDLE;
      cnt_d      = '0;
      idle_cnt_d = '0;
    end else if (state == IDLE) begin
      if (byte_valid) begin
        done_chan  = mode ? rr_ptr : chan_sel;
        done_mode  = mode;
        cur_chan_d = done_chan;
        cur_mode_d = mode;
        idle_cnt_d = '0;
        if (BYTES == 1) begin
          done = 1'b1;
        end else begin
          shreg_d = SR_W'(byte_in);
          cnt_d   = CNT_W'(1);
          state_d = ASSEMBLE;
        end
      end
    end else begin
      if (byte_valid) begin
        idle_cnt_d = '0;
        if (cnt == CNT_W'(BYTES - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          shreg_d = SR_W'({shreg, byte_in});
          cnt_d   = cnt + CNT_W'(1);
        end
      end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        err_timeout_d = 1'b1;
        drop_inc      = 1'b1;
        state_d       = IDLE;
        cnt_d         = '0;
        idle_cnt_d    = '0;
      end else begin
        idle_cnt_d = idle_cnt + IDLE_W'(1);
      end
    end

    // Completion: deliver to a valid channel, otherwise count it as dropped
    if (done) begin
      if ({1'b0, done_chan} < (SEL_W + 1)'(NUM_UNITS)) begin
        sample_out_d   = DATA_WIDTH'({shreg, byte_in});
        sample_chan_d  = done_chan;
        sample_valid_d = NUM_UNITS'(1) << done_chan;
        if (done_mode) begin
          rr_ptr_d = (rr_ptr == SEL_W'(NUM_UNITS - 1)) ? '0 : rr_ptr + SEL_W'(1);
        end
      end else begin
        drop_inc = 1'b1;
      end
    end

    if (drop_inc && (drop_count != 8'hFF)) drop_count_d = drop_count + 8'd1;

    busy_d = (state_d == ASSEMBLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      cur_chan     <= '0;
      cur_mode     <= 1'b0;
      rr_ptr       <= '0;
      idle_cnt     <= '0;
      sample_out   <= '0;
      sample_valid <= '0;
      sample_chan  <= '0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      drop_count   <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      shreg        <= shreg_d;
      cur_chan     <= cur_chan_d;
      cur_mode     <= cur_mode_d;
      rr_ptr       <= rr_ptr_d;
      idle_cnt     <= idle_cnt_d;
      sample_out   <= sample_out_d;
      sample_valid <= sample_valid_d;
      sample_chan  <= sample_chan_d;
      busy         <= busy_d;
      err_timeout  <= err_timeout_d;
      drop_count   <= drop_count_d;
    end
  end

endmodule
